// File: rtl/counter_event_monitor.sv
// Observer for the 8-bit programmable counter: detects compare-match and
// wrap events and queues tagged {type, seq} records in a small FIFO.
module counter_event_monitor #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  CMP_RESET  = 8'h80
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] count_in,
   input  logic       cmp_wr,
   input  logic [7:0] cmp_data,
   input  logic       clr,
   input  logic       evt_ready,
   output logic       evt_valid,
   output logic [7:0] evt_data,
   output logic       match_pulse,
   output logic       wrap_pulse,
   output logic [7:0] match_count,
   output logic       overflow
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   logic [7:0]    count_prev_q;
   logic          prev_valid_q;
   logic [7:0]    cmp_q, cmp_d;
   logic [5:0]    seq_q, seq_d;
   logic [7:0]    match_cnt_q, match_cnt_d;
   logic          ovf_q, ovf_d;
   logic          match_pulse_q;
   logic          wrap_pulse_q;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   occ_q, occ_d;

   logic       hit_match;
   logic       hit_wrap;
   logic       evt;
   logic       full;
   logic       empty;
   logic       pop;
   logic       push;
   logic       drop;
   logic [7:0] entry;

   // Detection always uses the registered compare value, so a write
   // takes effect from the following edge.
   always_comb begin
      hit_match = prev_valid_q
                & (count_in == cmp_q)
                & (count_prev_q != cmp_q);
      hit_wrap  = prev_valid_q
                & (count_prev_q == 8'hFF)
                & (count_in == 8'h00);
      evt       = hit_match | hit_wrap;
      full      = (occ_q == DEPTH_C);
      empty     = (occ_q == '0);
      pop       = ~empty & evt_ready;
      push      = evt & (~full | pop);
      drop      = evt & full & ~pop;
      entry     = {hit_wrap, hit_match, seq_q};
   end

   always_comb begin
      cmp_d    = cmp_q;
      seq_d    = seq_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (cmp_wr) begin
         cmp_d = cmp_data;
      end
      if (push) begin
         seq_d    = seq_q + 6'd1;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   // clr wins over a same-edge increment or drop.
   always_comb begin
      match_cnt_d = match_cnt_q;
      ovf_d       = ovf_q;
      unique case (1'b1)
         clr: begin
            match_cnt_d = 8'h00;
            ovf_d       = 1'b0;
         end
         default: begin
            if (hit_match && match_cnt_q != 8'hFF) begin
               match_cnt_d = match_cnt_q + 8'd1;
            end
            if (drop) begin
               ovf_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_prev_q  <= 8'h00;
         prev_valid_q  <= 1'b0;
         cmp_q         <= CMP_RESET;
         seq_q         <= 6'd0;
         match_cnt_q   <= 8'h00;
         ovf_q         <= 1'b0;
         match_pulse_q <= 1'b0;
         wrap_pulse_q  <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         occ_q         <= '0;
      end else begin
         count_prev_q  <= count_in;
         prev_valid_q  <= 1'b1;
         cmp_q         <= cmp_d;
         seq_q         <= seq_d;
         match_cnt_q   <= match_cnt_d;
         ovf_q         <= ovf_d;
         match_pulse_q <= hit_match;
         wrap_pulse_q  <= hit_wrap;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         occ_q         <= occ_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= entry;
      end
   end

   assign evt_valid   = ~empty;
   assign evt_data    = empty ? 8'h00 : mem_q[rd_ptr_q];
   assign match_pulse = match_pulse_q;
   assign wrap_pulse  = wrap_pulse_q;
   assign match_count = match_cnt_q;
   assign overflow    = ovf_q;

endmodule
